// File: rtl/mul_apx_pipe.sv
// rtl/mul_apx_pipe.sv - pipelined signed multiplier with exact/approximate mode select (optional MUL_APX_BIAS_COMP_EN)
module mul_apx_pipe #(
  parameter int WIDTH  = 8,
  parameter int TRUNC  = 2,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_exact,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 out_exact,
  output logic [CNT_W-1:0]     out_cnt
);

  localparam int PW = 2 * WIDTH;
  localparam int H  = WIDTH / 2;

  // Clearing the low TRUNC bits of a two's complement value rounds toward -inf.
  localparam logic [WIDTH-1:0] TMASK = {WIDTH{1'b1}} << TRUNC;

`ifdef MUL_APX_BIAS_COMP_EN
  localparam int BSH = (TRUNC >= 1) ? (2 * TRUNC - 2) : 0;
  localparam logic [PW-1:0] BIAS = (TRUNC >= 1) ? (PW'(1) << BSH) : '0;
`else
  localparam logic [PW-1:0] BIAS = '0;
`endif

  logic [WIDTH-1:0] a_t, b_t;
  logic [PW-1:0]    a_ext, lo_ext, hi_ext, bias_sel, pp_lo, pp_hi;

  // Per-stage state: valid, mode bit, and two partial sums. Only stage 0 ever
  // holds a nonzero high partial sum; stage 1 folds the two together.
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] s_ex;
  logic [PW-1:0]     s_lo [STAGES];
  logic [PW-1:0]     s_hi [STAGES];

  logic [STAGES:0]   go;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] ld;
  logic [CNT_W-1:0]  cnt;

  // Operand conditioning and split partial products (A*B = A*B_lo + (A*B_hi)<<H).
  always_comb begin
    a_t      = in_exact ? in_a : (in_a & TMASK);
    b_t      = in_exact ? in_b : (in_b & TMASK);
    a_ext    = {{WIDTH{a_t[WIDTH-1]}}, a_t};
    lo_ext   = {{(PW-H){1'b0}}, b_t[H-1:0]};
    hi_ext   = {{(WIDTH+H){b_t[WIDTH-1]}}, b_t[WIDTH-1:H]};
    bias_sel = in_exact ? '0 : BIAS;
    pp_lo    = (a_ext * lo_ext) + bias_sel;
    pp_hi    = (a_ext * hi_ext) << H;
  end

  // Elastic handshake: a stage can take data if empty or draining this cycle.
  always_comb begin
    go         = '0;
    adv        = '0;
    ld         = '0;
    go[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv[i] = v[i] && go[i+1];
      go[i]  = !v[i] || go[i+1];
    end
    ld[0] = in_valid && rst_n && go[0];
    for (int i = 1; i < STAGES; i++) begin
      ld[i] = adv[i-1];
    end
  end

  assign in_ready  = rst_n && go[0];
  assign out_valid = v[STAGES-1];
  assign out_p     = s_lo[STAGES-1];
  assign out_exact = s_ex[STAGES-1];
  assign out_cnt   = cnt;

  // Stage registers: valid bits track occupancy, payload moves only on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v    <= '0;
      s_ex <= '0;
      for (int i = 0; i < STAGES; i++) begin
        s_lo[i] <= '0;
        s_hi[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (ld[i]) begin
          v[i] <= 1'b1;
        end else if (adv[i]) begin
          v[i] <= 1'b0;
        end
      end
      if (ld[0]) begin
        s_ex[0] <= in_exact;
        if (STAGES == 1) begin
          s_lo[0] <= pp_lo + pp_hi;
          s_hi[0] <= '0;
        end else begin
          s_lo[0] <= pp_lo;
          s_hi[0] <= pp_hi;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (ld[i]) begin
          s_lo[i] <= s_lo[i-1] + s_hi[i-1];
          s_hi[i] <= '0;
          s_ex[i] <= s_ex[i-1];
        end
      end
    end
  end

  // Completed-transfer counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (out_valid && out_ready) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule
